// File: rtl/mem_stage.sv
// Memory stage: unpacks the EX/MEM word and serialises scalar or vector loads and stores
// onto a single-port req/ack data memory. Optional ack watchdog: define MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int N       = 24,
  parameter int M       = 6,
  parameter int BW      = 17 + 2*M*N,
  parameter int WBW     = 7 + 2*M*N,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [BW-1:0]  bufferIn,
  output logic           memReq,
  output logic           memWe,
  output logic [N-1:0]   memAddr,
  output logic [N-1:0]   memWdata,
  input  logic [N-1:0]   memRdata,
  input  logic           memAck,
  output logic           stall,
  output logic           memErr,
  output logic [WBW-1:0] bufferOut
);

  localparam int VW = M * N;
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  logic [VW-1:0] in_rd3, in_alu;
  logic [3:0]    in_rc;
  logic          in_regw, in_m2r, in_memw, in_mode, in_memop;
  logic          unused_fields;

  assign in_rd3   = bufferIn[VW-1:0];
  assign in_rc    = bufferIn[VW+3:VW];
  assign in_regw  = bufferIn[VW+4];
  assign in_m2r   = bufferIn[VW+5];
  assign in_memw  = bufferIn[VW+6];
  assign in_alu   = bufferIn[2*VW+9:VW+10];
  assign in_mode  = bufferIn[BW-1];
  assign in_memop = in_memw | in_m2r;
  assign unused_fields = ^{bufferIn[VW+9:VW+7], bufferIn[BW-2:2*VW+10]};

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d, nxt_idx, last_idx;
  logic           req_q, req_d, we_q, we_d;
  logic [N-1:0]   addr_q, addr_d, wdata_q, wdata_d, base;
  logic [WBW-1:0] out_q, out_d;
  logic [VW-1:0]  rd3_q, alu_q, mdata_q, mdata_d;
  logic [3:0]     rc_q;
  logic           regw_q, m2r_q, memw_q, mode_q;
  logic           cap, finish, ack_ok, expire;

  assign cap      = (state_q == IDLE) && en && in_memop;
  assign ack_ok   = (state_q == ACCESS) && req_q && memAck;
  assign base     = alu_q[N-1:0];
  assign nxt_idx  = idx_q + IW'(1);
  assign last_idx = mode_q ? IW'(M - 1) : '0;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Counts cycles an issued request has waited without an ack.
  always_comb begin
    tmo_d  = tmo_q;
    err_d  = err_q;
    expire = 1'b0;
    if (cap || ack_ok) begin
      tmo_d = '0;
    end else if ((state_q == ACCESS) && req_q) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        expire = 1'b1;
        err_d  = 1'b1;
        tmo_d  = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign memErr = err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire = 1'b0;
  assign memErr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    mdata_d = mdata_q;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = ACCESS;
          idx_d   = '0;
          mdata_d = '0;
        end else if (en) begin
          out_d = {in_mode, in_m2r, in_regw, in_rc, {VW{1'b0}}, in_alu};
        end
      end
      ACCESS: begin
        // First cycle issues element 0; each ack then advances to the next element.
        if (!req_q) begin
          req_d   = 1'b1;
          we_d    = memw_q;
          addr_d  = base + N'(idx_q);
          wdata_d = rd3_q[idx_q*N +: N];
        end else if (memAck) begin
          if (!memw_q) mdata_d[idx_q*N +: N] = memRdata;
          if (idx_q == last_idx) begin
            finish = 1'b1;
          end else begin
            idx_d   = nxt_idx;
            addr_d  = base + N'(nxt_idx);
            wdata_d = rd3_q[nxt_idx*N +: N];
          end
        end else if (expire) begin
          finish = 1'b1;
        end
        if (finish) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          idx_d   = '0;
          if (en) begin
            state_d = IDLE;
            out_d   = {mode_q, m2r_q, regw_q, rc_q, mdata_d, alu_q};
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (en) begin
          state_d = IDLE;
          out_d   = {mode_q, m2r_q, regw_q, rc_q, mdata_q, alu_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
    end
  end

  // Operand fields and gathered load data carry no reset; they are rebuilt at every capture.
  always_ff @(posedge clk) begin
    if (cap) begin
      rd3_q  <= in_rd3;
      alu_q  <= in_alu;
      rc_q   <= in_rc;
      regw_q <= in_regw;
      m2r_q  <= in_m2r;
      memw_q <= in_memw;
      mode_q <= in_mode;
    end
    mdata_q <= mdata_d;
  end

  assign memReq    = req_q;
  assign memWe     = we_q;
  assign memAddr   = addr_q;
  assign memWdata  = wdata_q;
  assign bufferOut = out_q;
  assign stall     = rst && ((state_q != IDLE) || in_memop);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, scalar/vector load and store, en hold in DONE,
// address wrap with mid-access reset, and the ack watchdog when MEM_STAGE_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_mem_stage;
  localparam int N   = 24;
  localparam int M   = 6;
  localparam int VW  = M * N;
  localparam int BW  = 17 + 2*VW;
  localparam int WBW = 7 + 2*VW;

  logic           clk = 1'b0;
  logic           rst, en, memReq, memWe, memAck, stall, memErr;
  logic [BW-1:0]  bufferIn;
  logic [N-1:0]   memAddr, memWdata, memRdata;
  logic [WBW-1:0] bufferOut;

  always #5 clk = ~clk;

  mem_stage #(.N(N), .M(M), .BW(BW), .WBW(WBW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .en(en), .bufferIn(bufferIn),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck), .stall(stall), .memErr(memErr),
    .bufferOut(bufferOut)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [N-1:0] rd_vals[M];
  logic [N-1:0] log_addr[M];
  logic [N-1:0] log_wdata[M];
  logic         log_we[M];

  task automatic check_eq(input string tag, input logic [WBW-1:0] got, input logic [WBW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_in(input logic mode, input logic memw, input logic m2r,
                                            input logic regw, input logic [3:0] rc,
                                            input logic [VW-1:0] alu, input logic [VW-1:0] rd3);
    logic [BW-1:0] w;
    w = '0;
    w[VW-1:0]        = rd3;
    w[VW+3:VW]       = rc;
    w[VW+4]          = regw;
    w[VW+5]          = m2r;
    w[VW+6]          = memw;
    w[VW+9:VW+7]     = 3'b101;
    w[2*VW+9:VW+10]  = alu;
    w[2*VW+15:2*VW+10] = 6'h2A;
    w[BW-1]          = mode;
    return w;
  endfunction

  function automatic logic [WBW-1:0] pack_out(input logic mode, input logic m2r, input logic regw,
                                              input logic [3:0] rc, input logic [VW-1:0] md,
                                              input logic [VW-1:0] alu);
    logic [WBW-1:0] w;
    w = '0;
    w[VW-1:0]      = alu;
    w[2*VW-1:VW]   = md;
    w[2*VW+3:2*VW] = rc;
    w[2*VW+4]      = regw;
    w[2*VW+5]      = m2r;
    w[2*VW+6]      = mode;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en       = 1'b0;
    bufferIn = '0;
  endtask

  // Memory responder: acks each element 'delay' cycles after it is requested and logs it.
  // cyc is the number of edges from the capture edge to the edge consuming the last ack.
  task automatic mem_run(input int nstop, input int delay, input int budget, input logic en_last,
                         output logic done, output int cyc, output logic stall_ok);
    int   waitc, nack;
    logic acked;
    waitc = 0; nack = 0; acked = 1'b0; done = 1'b0; cyc = 0; stall_ok = 1'b1;
    for (int c = 1; c <= budget && !done; c++) begin
      step();
      memAck = 1'b0;
      if (acked) begin
        nack++;
        acked = 1'b0;
      end
      if (nack == nstop) begin
        done = 1'b1;
        cyc  = c - 1;
      end else begin
        if (!stall) stall_ok = 1'b0;
        if (memReq) begin
          waitc++;
          if (waitc > delay) begin
            log_addr[nack]  = memAddr;
            log_wdata[nack] = memWdata;
            log_we[nack]    = memWe;
            memRdata = rd_vals[nack];
            memAck   = 1'b1;
            acked    = 1'b1;
            waitc    = 0;
            if (nack == nstop - 1) en = en_last;
          end
        end
      end
    end
    memAck = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic           done, sok;
    int             cyc;
    logic [VW-1:0]  v, md;
    logic [WBW-1:0] prev;

    rst = 1'b0; en = 1'b0; bufferIn = '0; memAck = 1'b0; memRdata = '0;
    for (int i = 0; i < M; i++) rd_vals[i] = '0;
    repeat (2) step();
    check_eq("rst_out",    bufferOut, '0);
    check_eq("rst_req",    WBW'(memReq), '0);
    check_eq("rst_we",     WBW'(memWe), '0);
    check_eq("rst_addr",   WBW'(memAddr), '0);
    check_eq("rst_wdata",  WBW'(memWdata), '0);
    check_eq("rst_stall",  WBW'(stall), '0);
    check_eq("rst_err",    WBW'(memErr), '0);
    rst = 1'b1;

    // Pass-through
    bufferIn = pack_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, VW'(6), '0);
    en = 1'b1;
    #1;
    check_eq("pt_stall_pre", WBW'(stall), '0);
    step();
    check_eq("pt_out",    bufferOut, pack_out(1'b0, 1'b0, 1'b1, 4'd3, '0, VW'(6)));
    check_eq("pt_alu_lo", WBW'(bufferOut[23:0]), WBW'(24'd6));
    check_eq("pt_stall",  WBW'(stall), '0);
    idle();

    // Scalar load, ack two cycles after the request
    rd_vals[0] = 24'hABCDEF;
    bufferIn = pack_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, VW'(24'h10), '0);
    en = 1'b1;
    #1;
    check_eq("ld_stall_pre", WBW'(stall), WBW'(1'b1));
    mem_run(1, 2, 30, 1'b1, done, cyc, sok);
    check_eq("ld_done",  WBW'(done), WBW'(1'b1));
    check_eq("ld_cyc",   WBW'(cyc), WBW'(4));
    check_eq("ld_stall", WBW'(sok), WBW'(1'b1));
    check_eq("ld_addr",  WBW'(log_addr[0]), WBW'(24'h10));
    check_eq("ld_we",    WBW'(log_we[0]), '0);
    check_eq("ld_out",   bufferOut, pack_out(1'b0, 1'b1, 1'b1, 4'd5, VW'(24'hABCDEF), VW'(24'h10)));
    check_eq("ld_req_drop", WBW'(memReq), '0);
    idle();

    // Vector store, ack every cycle
    v = '0;
    for (int i = 0; i < M; i++) v[i*N +: N] = N'(13 + i);
    bufferIn = pack_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, VW'(24'h20), v);
    en = 1'b1;
    mem_run(M, 0, 40, 1'b1, done, cyc, sok);
    check_eq("st_done", WBW'(done), WBW'(1'b1));
    check_eq("st_cyc",  WBW'(cyc), WBW'(7));
    for (int i = 0; i < M; i++) begin
      check_eq($sformatf("st_addr%0d", i),  WBW'(log_addr[i]),  WBW'(24'h20 + i));
      check_eq($sformatf("st_wdata%0d", i), WBW'(log_wdata[i]), WBW'(13 + i));
      check_eq($sformatf("st_we%0d", i),    WBW'(log_we[i]),    WBW'(1'b1));
    end
    check_eq("st_out", bufferOut, pack_out(1'b1, 1'b0, 1'b0, 4'd0, '0, VW'(24'h20)));
    idle();

    // Vector load with en low at the last ack: hold in DONE, release with en
    prev = bufferOut;
    md = '0;
    for (int i = 0; i < M; i++) begin
      rd_vals[i]     = N'(i + 1);
      md[i*N +: N]   = N'(i + 1);
    end
    bufferIn = pack_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, VW'(24'h40), '0);
    en = 1'b1;
    mem_run(M, 1, 60, 1'b0, done, cyc, sok);
    check_eq("vl_done",     WBW'(done), WBW'(1'b1));
    check_eq("vl_addr5",    WBW'(log_addr[5]), WBW'(24'h45));
    check_eq("vl_out_hold", bufferOut, prev);
    check_eq("vl_req",      WBW'(memReq), '0);
    bufferIn = '0;
    #1;
    check_eq("vl_done_stall", WBW'(stall), WBW'(1'b1));
    step();
    check_eq("vl_hold2", bufferOut, prev);
    en = 1'b1;
    step();
    en = 1'b0;
    check_eq("vl_out",   bufferOut, pack_out(1'b1, 1'b1, 1'b1, 4'd7, md, VW'(24'h40)));
    check_eq("vl_stall", WBW'(stall), '0);

    // memWrite with memToReg also set is a store
    rd_vals[0] = 24'hDEAD00;
    v = '0;
    v[N-1:0] = 24'h123456;
    bufferIn = pack_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, VW'(24'h77), v);
    en = 1'b1;
    mem_run(1, 0, 20, 1'b1, done, cyc, sok);
    check_eq("pr_done",  WBW'(done), WBW'(1'b1));
    check_eq("pr_we",    WBW'(log_we[0]), WBW'(1'b1));
    check_eq("pr_wdata", WBW'(log_wdata[0]), WBW'(24'h123456));
    check_eq("pr_out",   bufferOut, pack_out(1'b0, 1'b1, 1'b0, 4'd2, '0, VW'(24'h77)));
    idle();

    // Address wrap, then reset after two acks
    bufferIn = pack_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, VW'(24'hFFFFFE), '0);
    en = 1'b1;
    mem_run(2, 0, 20, 1'b1, done, cyc, sok);
    check_eq("wr_done",  WBW'(done), WBW'(1'b1));
    check_eq("wr_addr0", WBW'(log_addr[0]), WBW'(24'hFFFFFE));
    check_eq("wr_addr1", WBW'(log_addr[1]), WBW'(24'hFFFFFF));
    check_eq("wr_addr2", WBW'(memAddr), '0);
    check_eq("wr_req",   WBW'(memReq), WBW'(1'b1));
    rst = 1'b0;
    step();
    check_eq("mr_req",   WBW'(memReq), '0);
    check_eq("mr_stall", WBW'(stall), '0);
    check_eq("mr_out",   bufferOut, '0);
    check_eq("mr_addr",  WBW'(memAddr), '0);
    rst = 1'b1;
    idle();
    memAck = 1'b1;
    memRdata = 24'h5A5A5A;
    step();
    memAck = 1'b0;
    check_eq("late_ack_req", WBW'(memReq), '0);
    check_eq("late_ack_out", bufferOut, '0);
    check_eq("late_ack_stall", WBW'(stall), '0);

    // No ack at all
    bufferIn = pack_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, VW'(24'h55), '0);
    en = 1'b1;
`ifdef MEM_STAGE_TIMEOUT_EN
    mem_run(1, 1000, 50, 1'b1, done, cyc, sok);
    check_eq("to_err_early", WBW'(memErr), '0);
    mem_run(1, 1000, 40, 1'b1, done, cyc, sok);
    check_eq("to_err",   WBW'(memErr), WBW'(1'b1));
    check_eq("to_req",   WBW'(memReq), '0);
    check_eq("to_out",   bufferOut, pack_out(1'b0, 1'b1, 1'b1, 4'd9, '0, VW'(24'h55)));
    idle();
    #1;
    check_eq("to_stall", WBW'(stall), '0);
    step();
    check_eq("to_sticky", WBW'(memErr), WBW'(1'b1));
`else
    mem_run(1, 1000, 80, 1'b1, done, cyc, sok);
    check_eq("na_wait",  WBW'(done), '0);
    check_eq("na_err",   WBW'(memErr), '0);
    check_eq("na_req",   WBW'(memReq), WBW'(1'b1));
    check_eq("na_stall", WBW'(stall), WBW'(1'b1));
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle();
    step();
    check_eq("na_abort_req", WBW'(memReq), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
